// File: rtl/tfe_pkg.sv
// Shared constants, operand/result types and sequencer state encoding
// for the tensor front-end datapath.
package tfe_pkg;

    localparam int VAR_WIDTH  = 8;
    localparam int DATA_WIDTH = 2 * VAR_WIDTH;
    localparam int M_SIZE     = 4;

    typedef logic [VAR_WIDTH-1:0]  operand_t;
    typedef logic [DATA_WIDTH-1:0] result_t;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        LOAD,
        DONE
    } mac_seq_state_e;

endpackage

// File: rtl/mac_multiply_stage.sv
// Registered unsigned multiplier with valid flag; the product reads zero
// whenever valid is low so downstream never sees a stale value.
module mac_multiply_stage #(
    parameter int VAR_WIDTH  = tfe_pkg::VAR_WIDTH,
    parameter int DATA_WIDTH = tfe_pkg::DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  flush,
    input  logic                  load,
    input  logic [VAR_WIDTH-1:0]  a,
    input  logic [VAR_WIDTH-1:0]  b,
    output logic [DATA_WIDTH-1:0] product,
    output logic                  valid
);

    logic [DATA_WIDTH-1:0] a_ext_p0;
    logic [DATA_WIDTH-1:0] b_ext_p0;
    logic [DATA_WIDTH-1:0] prod_p1;
    logic                  vld_p1;

    assign a_ext_p0 = {{(DATA_WIDTH-VAR_WIDTH){1'b0}}, a};
    assign b_ext_p0 = {{(DATA_WIDTH-VAR_WIDTH){1'b0}}, b};

    // p0 -> p1: operands captured as a full-width product
    always_ff @(posedge clock) begin
        if (flush) begin
            prod_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (load) begin
            prod_p1 <= a_ext_p0 * b_ext_p0;
            vld_p1  <= 1'b1;
        end else begin
            prod_p1 <= '0;
            vld_p1  <= 1'b0;
        end
    end

    assign product = prod_p1;
    assign valid   = vld_p1;

endmodule

// File: rtl/matrix_mac_sequencer.sv
// Feeds one dot product of M_SIZE operand pairs into the accumulate unit:
// clear pulse, one registered product per accepted beat, done pulse.
module matrix_mac_sequencer #(
    parameter int VAR_WIDTH  = tfe_pkg::VAR_WIDTH,
    parameter int DATA_WIDTH = tfe_pkg::DATA_WIDTH,
    parameter int M_SIZE     = tfe_pkg::M_SIZE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [VAR_WIDTH-1:0]  a_in,
    input  logic [VAR_WIDTH-1:0]  b_in,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  acc_enable,
    output logic                  acc_clear,
    output logic                  dot_done,
    output logic                  busy
);

    import tfe_pkg::*;

    localparam int CNT_W = $clog2(M_SIZE);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(M_SIZE - 1);

    mac_seq_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             beat;
    logic             kill;

    assign beat = in_valid && (state_q == LOAD);
    // abort only matters once a dot product is under way
    assign kill = abort && (state_q != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) state_d = CLEAR;
            end
            CLEAR: begin
                state_d = LOAD;
                cnt_d   = '0;
            end
            LOAD: begin
                if (beat) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (kill) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // DONE is entered on the same edge that registers the last product,
    // so dot_done lines up with the final acc_enable
    mac_multiply_stage #(
        .VAR_WIDTH  (VAR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clock   (clock),
        .flush   (reset || kill),
        .load    (beat),
        .a       (a_in),
        .b       (b_in),
        .product (result),
        .valid   (acc_enable)
    );

    assign in_ready  = (state_q == LOAD);
    assign acc_clear = (state_q == CLEAR);
    assign dot_done  = (state_q == DONE);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Directed-vector bench for matrix_mac_sequencer with a downstream accumulator model.
module tb_matrix_mac_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic [15:0] result;
    logic        acc_enable;
    logic        acc_clear;
    logic        dot_done;
    logic        busy;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] acc_sum;
    int          clr_cnt;
    int          done_cnt;

    matrix_mac_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .result     (result),
        .acc_enable (acc_enable),
        .acc_clear  (acc_clear),
        .dot_done   (dot_done),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Downstream accumulate unit and pulse counters
    always @(posedge clock) begin
        if (acc_clear) acc_sum <= 32'd0;
        else if (acc_enable) acc_sum <= acc_sum + 32'(result);
        if (acc_clear) clr_cnt <= clr_cnt + 1;
        if (dot_done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".en"},   32'(acc_enable), 32'd0);
        chk({tag, ".res"},  32'(result), 32'd0);
        chk({tag, ".done"}, 32'(dot_done), 32'd0);
        chk({tag, ".clr"},  32'(acc_clear), 32'd0);
        chk({tag, ".rdy"},  32'(in_ready), 32'd0);
    endtask

    // One full dot product. Optional stall of stall_len cycles after beat
    // stall_after, optional start held high while busy.
    task automatic dot(input string tag,
                       input logic [7:0] av [4], input logic [7:0] bv [4],
                       input logic [31:0] ex [4], input logic [31:0] ex_sum,
                       input int stall_after, input int stall_len,
                       input bit start_busy);
        start = 1'b1;
        tick();
        start = start_busy;
        chk({tag, ".clr"}, 32'(acc_clear), 32'd1);
        chk({tag, ".clrrdy"}, 32'(in_ready), 32'd0);
        tick();
        chk({tag, ".ld_rdy"}, 32'(in_ready), 32'd1);
        chk({tag, ".ld_en"}, 32'(acc_enable), 32'd0);
        chk({tag, ".ld_clr"}, 32'(acc_clear), 32'd0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a_in = av[i];
            b_in = bv[i];
            tick();
            in_valid = 1'b0;
            a_in = 8'hAA;
            b_in = 8'h55;
            chk($sformatf("%s.res%0d", tag, i), 32'(result), ex[i]);
            chk($sformatf("%s.en%0d", tag, i), 32'(acc_enable), 32'd1);
            chk($sformatf("%s.done%0d", tag, i), 32'(dot_done), (i == 3) ? 32'd1 : 32'd0);
            if (i == stall_after) begin
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    chk($sformatf("%s.gap_en%0d", tag, s), 32'(acc_enable), 32'd0);
                    chk($sformatf("%s.gap_res%0d", tag, s), 32'(result), 32'd0);
                    chk($sformatf("%s.gap_rdy%0d", tag, s), 32'(in_ready), 32'd1);
                end
            end
        end
        tick();
        start = 1'b0;
        chk_idle({tag, ".end"});
        chk({tag, ".sum"}, acc_sum, ex_sum);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        a_in = 8'd0; b_in = 8'd0;
        acc_sum = 32'd0; clr_cnt = 0; done_cnt = 0;
        tick();
        tick();
        reset = 1'b0;
        chk_idle("rst");

        // Basic dot product: 1*5 + 2*6 + 3*7 + 4*8 = 70
        dot("basic", '{8'd1, 8'd2, 8'd3, 8'd4}, '{8'd5, 8'd6, 8'd7, 8'd8},
            '{32'd5, 32'd12, 32'd21, 32'd32}, 32'd70, -1, 0, 1'b0);
        chk("basic.nclr", 32'(clr_cnt), 32'd1);
        chk("basic.ndone", 32'(done_cnt), 32'd1);

        // Max operands, no truncation: 255*255 = 0xFE01
        dot("max", '{8'd255, 8'd255, 8'd255, 8'd255}, '{8'd255, 8'd255, 8'd255, 8'd255},
            '{32'hFE01, 32'hFE01, 32'hFE01, 32'hFE01}, 32'h3F804, -1, 0, 1'b0);

        // Three-cycle stall after beat 2: 10*3 + 20*3 + 30*3 + 40*3 = 300
        dot("stall", '{8'd10, 8'd20, 8'd30, 8'd40}, '{8'd3, 8'd3, 8'd3, 8'd3},
            '{32'd30, 32'd60, 32'd90, 32'd120}, 32'd300, 1, 3, 1'b0);

        // Abort after two beats, with an in-flight beat in the abort cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1; a_in = 8'd2; b_in = 8'd2;
        tick();
        chk("abort.res0", 32'(result), 32'd4);
        a_in = 8'd3; b_in = 8'd3;
        tick();
        chk("abort.res1", 32'(result), 32'd9);
        a_in = 8'd9; b_in = 8'd9; abort = 1'b1;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        chk_idle("abort.idle");
        tick();
        chk_idle("abort.idle2");
        chk("abort.ndone", 32'(done_cnt), 32'd3);

        // Fresh dot product after abort
        dot("post_abort", '{8'd7, 8'd0, 8'd1, 8'd100}, '{8'd6, 8'd200, 8'd1, 8'd2},
            '{32'd42, 32'd0, 32'd1, 32'd200}, 32'd243, -1, 0, 1'b0);

        // Reset mid-LOAD after one beat
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1; a_in = 8'd12; b_in = 8'd11;
        tick();
        chk("rstmid.res0", 32'(result), 32'd132);
        a_in = 8'd5; b_in = 8'd5; reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        chk_idle("rstmid");

        // start and abort together in IDLE: stays IDLE
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk_idle("startabort");
        tick();
        chk_idle("startabort2");

        // start held high through LOAD and DONE is ignored
        clr_cnt = 0; done_cnt = 0;
        dot("busy_start", '{8'd2, 8'd4, 8'd6, 8'd8}, '{8'd1, 8'd1, 8'd1, 8'd1},
            '{32'd2, 32'd4, 32'd6, 32'd8}, 32'd20, 2, 1, 1'b1);
        tick();
        chk_idle("busy_start.after");
        chk("busy_start.nclr", 32'(clr_cnt), 32'd1);
        chk("busy_start.ndone", 32'(done_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
